// File: rtl/nat_tuple_extract_if.sv
// Packet stream bundle (data, byte enables, valid/ready, last) shared by the
// snooped input side and the forwarded output side of the tuple extractor.
interface nat_tuple_extract_if #(
  parameter int DATA_W = 64
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/nat_tuple_extract.sv
// Snoops a 64-bit Ethernet/IPv4 stream and emits one 5-tuple per TCP/UDP packet
// for the NAT hash stage. Beats pass straight through; only a blocked tuple stalls.
module nat_tuple_extract #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  nat_tuple_extract_if.slave  s,
  nat_tuple_extract_if.master m,
  output logic [127:0]        tuple_data,
  output logic                tuple_valid,
  input  logic                tuple_ready,
  output logic [CNT_W-1:0]    skip_count
);

  localparam int NBYTES = DATA_W / 8;
  localparam logic [0:0] ST_HDR     = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [2:0]       beat_reg, beat_next;
  logic             fail_reg, fail_next;
  logic [7:0]       proto_reg;
  logic [31:0]      src_ip_reg;
  logic [15:0]      dst_ip_hi_reg;
  logic [127:0]     tuple_reg;
  logic             tuple_valid_reg;
  logic [CNT_W-1:0] skip_reg;

  logic             stall;
  logic             xfer;
  logic             beat_fail;
  logic             load_tuple;
  logic             skip_inc;
  logic [127:0]     new_tuple;
  logic [7:0]       beat_byte [NBYTES];

  // Byte k of the beat is wire byte 8*beat+k.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign beat_byte[gi] = s.tdata[8*gi +: 8];
    end
  endgenerate

  assign stall    = (state_reg == ST_HDR) && (beat_reg == 3'd4) && tuple_valid_reg && !tuple_ready;
  assign m.tdata  = s.tdata;
  assign m.tkeep  = s.tkeep;
  assign m.tlast  = s.tlast;
  assign m.tvalid = s.tvalid && !stall;
  assign s.tready = m.tready && !stall;
  assign xfer     = s.tvalid && s.tready;

  // Beat 4 carries dst_ip low half and both ports; the rest was latched earlier.
  assign new_tuple = {24'h0, src_ip_reg, dst_ip_hi_reg, beat_byte[0], beat_byte[1],
                      beat_byte[2], beat_byte[3], beat_byte[4], beat_byte[5], proto_reg};

  always_comb begin
    beat_fail = 1'b0;
    case (beat_reg)
      3'd1: begin
        if ({beat_byte[4], beat_byte[5]} != 16'h0800 || beat_byte[6] != 8'h45)
          beat_fail = 1'b1;
      end
      3'd2: begin
        if (({beat_byte[4], beat_byte[5]} & 16'h3FFF) != 16'h0000)
          beat_fail = 1'b1;
        if (beat_byte[7] != 8'd6 && beat_byte[7] != 8'd17)
          beat_fail = 1'b1;
      end
      default: beat_fail = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    fail_next  = fail_reg;
    load_tuple = 1'b0;
    skip_inc   = 1'b0;
    if (xfer) begin
      if (state_reg == ST_HDR) begin
        if (beat_reg != 3'd4) begin
          if (s.tlast) begin
            skip_inc  = 1'b1;
            beat_next = 3'd0;
            fail_next = 1'b0;
          end else begin
            beat_next = beat_reg + 3'd1;
            fail_next = fail_reg | beat_fail;
          end
        end else begin
          beat_next  = 3'd0;
          fail_next  = 1'b0;
          skip_inc   = fail_reg;
          load_tuple = !fail_reg;
          state_next = s.tlast ? ST_HDR : ST_PAYLOAD;
        end
      end else if (s.tlast) begin
        state_next = ST_HDR;
        beat_next  = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_HDR;
      beat_reg        <= 3'd0;
      fail_reg        <= 1'b0;
      proto_reg       <= 8'd0;
      src_ip_reg      <= 32'd0;
      dst_ip_hi_reg   <= 16'd0;
      tuple_reg       <= 128'd0;
      tuple_valid_reg <= 1'b0;
      skip_reg        <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      fail_reg  <= fail_next;
      if (xfer && state_reg == ST_HDR && beat_reg == 3'd2)
        proto_reg <= beat_byte[7];
      if (xfer && state_reg == ST_HDR && beat_reg == 3'd3) begin
        src_ip_reg    <= {beat_byte[2], beat_byte[3], beat_byte[4], beat_byte[5]};
        dst_ip_hi_reg <= {beat_byte[6], beat_byte[7]};
      end
      // A fresh load wins over a same-cycle acceptance of the old tuple.
      if (load_tuple) begin
        tuple_reg       <= new_tuple;
        tuple_valid_reg <= 1'b1;
      end else if (tuple_valid_reg && tuple_ready) begin
        tuple_valid_reg <= 1'b0;
      end
      if (skip_inc && skip_reg != {CNT_W{1'b1}})
        skip_reg <= skip_reg + 1'b1;
    end
  end

  assign tuple_data  = tuple_reg;
  assign tuple_valid = tuple_valid_reg;
  assign skip_count  = skip_reg;

endmodule

// File: tb/tb_nat_tuple_extract.sv
// Directed bench for nat_tuple_extract: tuple extraction, stall/handshake, rejects,
// downstream back-pressure, mid-packet reset and a 2-bit saturating skip counter.
module tb_nat_tuple_extract;

  localparam logic [127:0] T1 = 128'h000000_0A000001_08080808_04D2_0035_11;
  localparam logic [127:0] T2 = 128'h000000_C0A8010A_01020304_9C40_0050_06;
  localparam logic [127:0] T3 = 128'h000000_AC100005_5DB8D822_0401_01BB_06;
  localparam logic [127:0] T4 = 128'h000000_0A010203_0A090807_1388_1770_11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tuple_ready;
  logic [127:0] tuple_data, tuple_data2;
  logic         tuple_valid, tuple_valid2;
  logic [15:0]  skip_count;
  logic [1:0]   skip_count2;

  always #5 clk = ~clk;

  nat_tuple_extract_if #(.DATA_W(64)) s_if ();
  nat_tuple_extract_if #(.DATA_W(64)) m_if ();
  nat_tuple_extract_if #(.DATA_W(64)) s2_if ();
  nat_tuple_extract_if #(.DATA_W(64)) m2_if ();

  // Second instance with a 2-bit counter runs in lockstep on the same stimulus.
  assign s2_if.tdata  = s_if.tdata;
  assign s2_if.tkeep  = s_if.tkeep;
  assign s2_if.tvalid = s_if.tvalid;
  assign s2_if.tlast  = s_if.tlast;
  assign m2_if.tready = m_if.tready;

  nat_tuple_extract #(.DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n), .s(s_if.slave), .m(m_if.master),
    .tuple_data(tuple_data), .tuple_valid(tuple_valid),
    .tuple_ready(tuple_ready), .skip_count(skip_count)
  );

  nat_tuple_extract #(.DATA_W(64), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(rst_n), .s(s2_if.slave), .m(m2_if.master),
    .tuple_data(tuple_data2), .tuple_valid(tuple_valid2),
    .tuple_ready(tuple_ready), .skip_count(skip_count2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  pkt [0:127];
  int          pkt_beats;
  logic [7:0]  last_keep;
  logic [72:0] fwd_q[$];
  logic [72:0] exp_q[$];
  logic [127:0] tuple_q[$];
  int          valid_cycles;

  always @(negedge clk) begin
    if (m_if.tvalid && m_if.tready) fwd_q.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
    if (tuple_valid && tuple_ready) tuple_q.push_back(tuple_data);
    if (tuple_valid) valid_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic build_pkt(input logic [15:0] etype, input logic [7:0] vihl,
                           input logic [15:0] frag, input logic [7:0] proto,
                           input logic [31:0] sip, input logic [31:0] dip,
                           input logic [15:0] sp, input logic [15:0] dp,
                           input int nbeats, input logic [7:0] lkeep);
    for (int i = 0; i < 128; i++) pkt[i] = 8'(i * 7 + 3);
    pkt[12] = etype[15:8]; pkt[13] = etype[7:0];
    pkt[14] = vihl;
    pkt[20] = frag[15:8];  pkt[21] = frag[7:0];
    pkt[23] = proto;
    pkt[26] = sip[31:24];  pkt[27] = sip[23:16]; pkt[28] = sip[15:8]; pkt[29] = sip[7:0];
    pkt[30] = dip[31:24];  pkt[31] = dip[23:16]; pkt[32] = dip[15:8]; pkt[33] = dip[7:0];
    pkt[34] = sp[15:8];    pkt[35] = sp[7:0];
    pkt[36] = dp[15:8];    pkt[37] = dp[7:0];
    pkt_beats = nbeats;
    last_keep = lkeep;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_if.tready) begin
        @(posedge clk);
        #1;
        exp_q.push_back({l, k, d});
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_beat_timeout: s_tready=0 for %0d cycles, required 1", waited);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_range(input int first, input int last_b);
    for (int b = first; b <= last_b; b++) begin
      logic [63:0] d;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = pkt[8*b + k];
      send_beat(d, (b == pkt_beats - 1) ? last_keep : 8'hFF, b == pkt_beats - 1);
    end
  endtask

  task automatic send_pkt();
    send_range(0, pkt_beats - 1);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    fwd_q.delete();
    exp_q.delete();
    tuple_q.delete();
    valid_cycles = 0;
  endtask

  task automatic build_t1(input int nbeats);
    build_pkt(16'h0800, 8'h45, 16'h4000, 8'd17, 32'h0A000001, 32'h08080808,
              16'd1234, 16'd53, nbeats, 8'hFF);
  endtask

  task automatic send_rejects();
    build_pkt(16'h86DD, 8'h45, 16'h0000, 8'd17, 32'h01010101, 32'h02020202, 16'd1, 16'd2, 8, 8'hFF);
    send_pkt();
    build_pkt(16'h0800, 8'h46, 16'h0000, 8'd17, 32'h01010101, 32'h02020202, 16'd1, 16'd2, 8, 8'hFF);
    send_pkt();
    build_pkt(16'h0800, 8'h45, 16'h0000, 8'd1, 32'h01010101, 32'h02020202, 16'd1, 16'd2, 8, 8'hFF);
    send_pkt();
    build_pkt(16'h0800, 8'h45, 16'h0001, 8'd6, 32'h01010101, 32'h02020202, 16'd1, 16'd2, 8, 8'hFF);
    send_pkt();
    build_pkt(16'h0800, 8'h45, 16'h0000, 8'd6, 32'h01010101, 32'h02020202, 16'd1, 16'd2, 3, 8'h0F);
    send_pkt();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    tuple_ready = 1'b0;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (tuple_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tuple_valid: got %b, expected 0", tuple_valid); end
    n_checks++; if (tuple_data !== 128'd0) begin n_fail++; $display("FAIL reset_tuple_data: got %h, expected 0", tuple_data); end
    n_checks++; if (skip_count !== 16'd0) begin n_fail++; $display("FAIL reset_skip_count: got %0d, expected 0", skip_count); end
    n_checks++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_s_tready: got %b, expected 1", s_if.tready); end
    n_checks++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b, expected 0", m_if.tvalid); end
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_udp_stream();
    clear_logs();
    tuple_ready = 1'b1;
    build_t1(8);
    send_range(0, 3);
    n_checks++; if (tuple_valid !== 1'b0) begin n_fail++; $display("FAIL udp_valid_before_beat4: got %b, expected 0", tuple_valid); end
    send_range(4, 4);
    n_checks++; if (tuple_valid !== 1'b1) begin n_fail++; $display("FAIL udp_latency: tuple_valid got %b, expected 1", tuple_valid); end
    n_checks++; if (tuple_data !== T1) begin n_fail++; $display("FAIL udp_tuple_data: got %h, expected %h", tuple_data, T1); end
    send_range(5, 7);
    s_if.tvalid = 1'b0;
    idle(2);
    n_checks++; if (tuple_q.size() != 1) begin n_fail++; $display("FAIL udp_tuple_count: got %0d, expected 1", tuple_q.size()); end
    else begin
      n_checks++; if (tuple_q[0] !== T1) begin n_fail++; $display("FAIL udp_tuple_taken: got %h, expected %h", tuple_q[0], T1); end
    end
    n_checks++; if (valid_cycles != 1) begin n_fail++; $display("FAIL udp_valid_pulse: got %0d cycles, expected 1", valid_cycles); end
    n_checks++; if (skip_count !== 16'd0) begin n_fail++; $display("FAIL udp_skip_count: got %0d, expected 0", skip_count); end
    n_checks++; if (fwd_q.size() != 8) begin n_fail++; $display("FAIL udp_fwd_count: got %0d, expected 8", fwd_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_checks++; if (fwd_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL udp_fwd_beat%0d: got %h, expected %h", i, fwd_q[i], exp_q[i]); end
    end
    $display("test_udp_stream done: %0d tuples", tuple_q.size());
  endtask

  task automatic test_back_to_back();
    clear_logs();
    tuple_ready = 1'b0;
    build_pkt(16'h0800, 8'h45, 16'h0000, 8'd6, 32'hC0A8010A, 32'h01020304, 16'd40000, 16'd80, 6, 8'hFF);
    send_pkt();
    idle(2);
    n_checks++; if (tuple_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_held: tuple_valid got %b, expected 1", tuple_valid); end
    n_checks++; if (tuple_data !== T2) begin n_fail++; $display("FAIL b2b_first_data: got %h, expected %h", tuple_data, T2); end
    build_pkt(16'h0800, 8'h45, 16'h0000, 8'd6, 32'hAC100005, 32'h5DB8D822, 16'd1025, 16'd443, 8, 8'hFF);
    send_range(0, 3);
    for (int k = 0; k < 8; k++) s_if.tdata[8*k +: 8] = pkt[32 + k];
    s_if.tkeep  = 8'hFF;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_s_tready: got %b, expected 0", s_if.tready); end
      n_checks++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_m_tvalid: got %b, expected 0", m_if.tvalid); end
    end
    n_checks++; if (tuple_data !== T2) begin n_fail++; $display("FAIL b2b_stall_data_stable: got %h, expected %h", tuple_data, T2); end
    @(posedge clk);
    #1;
    tuple_ready = 1'b1;
    send_beat(s_if.tdata, 8'hFF, 1'b0);
    n_checks++; if (tuple_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b, expected 1", tuple_valid); end
    n_checks++; if (tuple_data !== T3) begin n_fail++; $display("FAIL b2b_second_data: got %h, expected %h", tuple_data, T3); end
    send_range(5, 7);
    s_if.tvalid = 1'b0;
    idle(2);
    n_checks++; if (tuple_q.size() != 2) begin n_fail++; $display("FAIL b2b_tuple_count: got %0d, expected 2", tuple_q.size()); end
    else begin
      n_checks++; if (tuple_q[0] !== T2) begin n_fail++; $display("FAIL b2b_taken0: got %h, expected %h", tuple_q[0], T2); end
      n_checks++; if (tuple_q[1] !== T3) begin n_fail++; $display("FAIL b2b_taken1: got %h, expected %h", tuple_q[1], T3); end
    end
    n_checks++; if (fwd_q.size() != 14) begin n_fail++; $display("FAIL b2b_fwd_count: got %0d, expected 14", fwd_q.size()); end
    $display("test_back_to_back done: %0d tuples", tuple_q.size());
  endtask

  task automatic test_exact_end();
    clear_logs();
    tuple_ready = 1'b1;
    build_pkt(16'h0800, 8'h45, 16'h0000, 8'd17, 32'h0A010203, 32'h0A090807, 16'd5000, 16'd6000, 5, 8'h3F);
    send_pkt();
    idle(2);
    n_checks++; if (tuple_q.size() != 1) begin n_fail++; $display("FAIL exact_end_count: got %0d, expected 1", tuple_q.size()); end
    else begin
      n_checks++; if (tuple_q[0] !== T4) begin n_fail++; $display("FAIL exact_end_tuple: got %h, expected %h", tuple_q[0], T4); end
    end
    n_checks++; if (skip_count !== 16'd0) begin n_fail++; $display("FAIL exact_end_skip: got %0d, expected 0", skip_count); end
    $display("test_exact_end done: %0d tuples", tuple_q.size());
  endtask

  task automatic test_rejects();
    clear_logs();
    tuple_ready = 1'b1;
    send_rejects();
    idle(2);
    n_checks++; if (valid_cycles != 0) begin n_fail++; $display("FAIL rejects_tuple_valid: got %0d valid cycles, expected 0", valid_cycles); end
    n_checks++; if (skip_count !== 16'd5) begin n_fail++; $display("FAIL rejects_skip_count: got %0d, expected 5", skip_count); end
    n_checks++; if (fwd_q.size() != 35) begin n_fail++; $display("FAIL rejects_fwd_count: got %0d, expected 35", fwd_q.size()); end
    else for (int i = 0; i < 35; i++) begin
      n_checks++; if (fwd_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rejects_fwd_beat%0d: got %h, expected %h", i, fwd_q[i], exp_q[i]); end
    end
    $display("test_rejects done: skip_count=%0d", skip_count);
  endtask

  task automatic test_backpressure();
    clear_logs();
    tuple_ready = 1'b1;
    build_t1(8);
    fork
      send_pkt();
      begin
        for (int i = 0; i < 12; i++) begin
          m_if.tready = (i % 2 == 0);
          @(posedge clk);
          #1;
        end
        m_if.tready = 1'b1;
      end
    join
    idle(2);
    n_checks++; if (tuple_q.size() != 1) begin n_fail++; $display("FAIL bp_tuple_count: got %0d, expected 1", tuple_q.size()); end
    else begin
      n_checks++; if (tuple_q[0] !== T1) begin n_fail++; $display("FAIL bp_tuple: got %h, expected %h", tuple_q[0], T1); end
    end
    n_checks++; if (fwd_q.size() != 8) begin n_fail++; $display("FAIL bp_fwd_count: got %0d, expected 8", fwd_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_checks++; if (fwd_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_fwd_beat%0d: got %h, expected %h", i, fwd_q[i], exp_q[i]); end
    end
    $display("test_backpressure done: %0d beats forwarded", fwd_q.size());
  endtask

  task automatic test_reset_mid_payload();
    tuple_ready = 1'b0;
    build_t1(8);
    send_range(0, 5);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    n_checks++; if (tuple_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pending: got %b, expected 1", tuple_valid); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++; if (tuple_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_tuple_valid: got %b, expected 0", tuple_valid); end
    n_checks++; if (skip_count !== 16'd0) begin n_fail++; $display("FAIL midrst_skip_count: got %0d, expected 0", skip_count); end
    clear_logs();
    tuple_ready = 1'b1;
    build_pkt(16'h0800, 8'h45, 16'h0000, 8'd6, 32'hC0A8010A, 32'h01020304, 16'd40000, 16'd80, 8, 8'hFF);
    send_pkt();
    idle(2);
    n_checks++; if (tuple_q.size() != 1) begin n_fail++; $display("FAIL midrst_tuple_count: got %0d, expected 1", tuple_q.size()); end
    else begin
      n_checks++; if (tuple_q[0] !== T2) begin n_fail++; $display("FAIL midrst_tuple: got %h, expected %h", tuple_q[0], T2); end
    end
    $display("test_reset_mid_payload done: %0d tuples", tuple_q.size());
  endtask

  task automatic test_saturation();
    clear_logs();
    tuple_ready = 1'b1;
    send_rejects();
    idle(2);
    n_checks++; if (skip_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_skip_count_w2: got %0d, expected 3", skip_count2); end
    n_checks++; if (skip_count !== 16'd5) begin n_fail++; $display("FAIL sat_skip_count_w16: got %0d, expected 5", skip_count); end
    $display("test_saturation done: skip_count(CNT_W=2)=%0d", skip_count2);
  endtask

  initial begin
    test_reset();
    test_udp_stream();
    test_back_to_back();
    test_exact_end();
    test_rejects();
    test_backpressure();
    test_reset_mid_payload();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
